tri_feeder: RTL and testbench

- Synthesizable triangle source; transmit end of the triangle interface whose traffic the rasterizer performance monitor counts.
- Buffers triangles loaded by a host or testbench write port in an internal FIFO.
- Presents them to the rasterizer front end as tri_R10S/color_R10U/validTri_R10H, honouring the active-low halt backpressure.
- Counts triangles sent and stall cycles, and signals end-of-stream completion.

---
 rtl/tri_feeder.sv | 157 +++++++++++++++
 tb/tb_tri_feeder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_feeder.sv
// tri_feeder: buffers host-written triangles in a small FIFO and presents them
// to the rasterizer front end one per cycle, honouring the active-low halt.
// Also counts delivered triangles and stall cycles, and flags end of stream.
module tri_feeder #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [SIGFIG-1:0]        wr_tri [VERTS][AXIS],
    input  logic [SIGFIG-1:0]        wr_color [COLORS],
    input  logic                     wr_last,
    output logic                     wr_full,
    output logic                     overflow,
    output logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
    output logic [SIGFIG-1:0]        color_R10U [COLORS],
    output logic                     validTri_R10H,
    input  logic                     halt_RnnnnL,
    output logic [CNT_W-1:0]         tri_sent_count,
    output logic [CNT_W-1:0]         stall_count,
    output logic                     done
);

    localparam int NCOORD  = VERTS * AXIS;
    localparam int TRI_W   = NCOORD * SIGFIG;
    localparam int COL_W   = COLORS * SIGFIG;
    localparam int ENTRY_W = TRI_W + COL_W + 1;   // last flag in the MSB
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = AW + 1;

    // Fraction bits are informational only; nothing in the datapath depends on them.
    if (RADIX < SIGFIG) begin : g_radix_info
    end

    logic [ENTRY_W-1:0] wr_flat;
    logic [ENTRY_W-1:0] head_flat;
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill;

    logic               valid_q, valid_d;
    logic [ENTRY_W-1:0] data_q, data_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic fifo_empty;
    logic fifo_full;
    logic transfer;
    logic load;
    logic push;

    // Flatten the incoming triangle into one FIFO word and unflatten the output stage.
    for (genvar gi = 0; gi < NCOORD; gi++) begin : g_coord
        assign wr_flat[gi*SIGFIG +: SIGFIG]        = wr_tri[gi/AXIS][gi%AXIS];
        assign tri_R10S[gi/AXIS][gi%AXIS]          = $signed(data_q[gi*SIGFIG +: SIGFIG]);
    end
    for (genvar gi = 0; gi < COLORS; gi++) begin : g_color
        assign wr_flat[TRI_W + gi*SIGFIG +: SIGFIG] = wr_color[gi];
        assign color_R10U[gi]                       = data_q[TRI_W + gi*SIGFIG +: SIGFIG];
    end
    assign wr_flat[ENTRY_W-1] = wr_last;

    // Occupancy comes straight from the pointers; full is judged before any pop this edge.
    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == PTR_W'(FIFO_DEPTH));
    assign head_flat  = mem[rd_ptr_q[AW-1:0]];

    assign transfer = valid_q & halt_RnnnnL;
    assign load     = (~valid_q | transfer) & ~fifo_empty;
    assign push     = wr_en & ~fifo_full;

    // FIFO storage: plain registered entries, no reset needed since pointers gate use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_flat;
        end
    end

    // Next-state for pointers, output stage, flags and counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        valid_d    = valid_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        sent_d     = sent_q;
        stall_d    = stall_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (wr_en && fifo_full) begin
            overflow_d = 1'b1;
        end

        if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            valid_d  = 1'b1;
            data_d   = head_flat;
        end else if (transfer) begin
            valid_d = 1'b0;
        end

        if (transfer) begin
            sent_d = sent_q + CNT_W'(1);
            if (data_q[ENTRY_W-1]) begin
                done_d = 1'b1;
            end
        end
        if (valid_q && !halt_RnnnnL) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State register; an async reset discards buffered and in-flight triangles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            sent_q     <= '0;
            stall_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            sent_q     <= sent_d;
            stall_q    <= stall_d;
        end
    end

    assign wr_full        = fifo_full;
    assign overflow       = overflow_q;
    assign validTri_R10H  = valid_q;
    assign tri_sent_count = sent_q;
    assign stall_count    = stall_q;
    assign done           = done_q;

endmodule

// File: tb/tb_tri_feeder.sv
// Directed testbench for tri_feeder: one transaction/check per line.
module tb_tri_feeder;

    localparam int SIGFIG = 24;
    localparam int CNT_W  = 32;

    logic                     clk;
    logic                     rst;
    logic                     wr_en;
    logic [SIGFIG-1:0]        wr_tri [3][3];
    logic [SIGFIG-1:0]        wr_color [3];
    logic                     wr_last;
    logic                     wr_full;
    logic                     overflow;
    logic signed [SIGFIG-1:0] tri_R10S [3][3];
    logic [SIGFIG-1:0]        color_R10U [3];
    logic                     validTri_R10H;
    logic                     halt_RnnnnL;
    logic [CNT_W-1:0]         tri_sent_count;
    logic [CNT_W-1:0]         stall_count;
    logic                     done;

    int n_checks = 0;
    int n_pass   = 0;

    tri_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_tri         (wr_tri),
        .wr_color       (wr_color),
        .wr_last        (wr_last),
        .wr_full        (wr_full),
        .overflow       (overflow),
        .tri_R10S       (tri_R10S),
        .color_R10U     (color_R10U),
        .validTri_R10H  (validTri_R10H),
        .halt_RnnnnL    (halt_RnnnnL),
        .tri_sent_count (tri_sent_count),
        .stall_count    (stall_count),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-chosen triangle contents: index 0 is the test-plan triangle.
    function automatic logic [SIGFIG-1:0] tri_val(input int n, input int v, input int a);
        logic [SIGFIG-1:0] r;
        if (n == 0) begin
            if (a == 2)                r = 24'h000000;
            else if (v == 1 && a == 0) r = 24'h000800;
            else if (v == 2 && a == 1) r = 24'h000800;
            else                       r = 24'h000400;
        end else begin
            r = 24'h800000 | SIGFIG'(n << 8) | SIGFIG'(v << 4) | SIGFIG'(a);
        end
        return r;
    endfunction

    function automatic logic [SIGFIG-1:0] col_val(input int n, input int c);
        if (n == 0) return 24'h0003FF;
        return 24'hF00000 | SIGFIG'(n << 4) | SIGFIG'(c);
    endfunction

    function automatic logic [215:0] exp_tri(input int n);
        logic [215:0] r;
        r = '0;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                r[(v*3+a)*SIGFIG +: SIGFIG] = tri_val(n, v, a);
        return r;
    endfunction

    function automatic logic [71:0] exp_col(input int n);
        logic [71:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) r[c*SIGFIG +: SIGFIG] = col_val(n, c);
        return r;
    endfunction

    logic [215:0] dut_tri_flat;
    logic [71:0]  dut_col_flat;
    always_comb begin
        dut_tri_flat = '0;
        dut_col_flat = '0;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                dut_tri_flat[(v*3+a)*SIGFIG +: SIGFIG] = tri_R10S[v][a];
        for (int c = 0; c < 3; c++) dut_col_flat[c*SIGFIG +: SIGFIG] = color_R10U[c];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_data(input string tag, input int n);
        check({tag, "_tri"}, {40'h0, dut_tri_flat}, {40'h0, exp_tri(n)});
        check({tag, "_col"}, {184'h0, dut_col_flat}, {184'h0, exp_col(n)});
    endtask

    task automatic set_wr(input int n, input logic en, input logic last);
        wr_en   = en;
        wr_last = last;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                wr_tri[v][a] = tri_val(n, v, a);
        for (int c = 0; c < 3; c++) wr_color[c] = col_val(n, c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_wr(0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        $display("reset pulse done");
    endtask

    // Expected per-edge results for the halt-toggling stream of triangles 30..32.
    logic [0:7] t5_valid = 8'b0111_1100;
    int         t5_sent  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int         t5_stall [8] = '{0, 0, 0, 1, 1, 2, 2, 2};
    logic [0:7] t5_done  = 8'b0000_0011;
    int         t5_tri   [8] = '{0, 30, 31, 31, 32, 32, 0, 0};

    initial begin
        rst         = 1'b1;
        halt_RnnnnL = 1'b1;
        set_wr(0, 1'b0, 1'b0);
        #3;
        // ---- reset state ----
        check("rst_valid", validTri_R10H, 1'b0);
        check("rst_full", wr_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_sent", tri_sent_count, 32'd0);
        check("rst_stall", stall_count, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_tri", {40'h0, dut_tri_flat}, 256'h0);
        check("rst_col", {184'h0, dut_col_flat}, 256'h0);
        tick();
        rst = 1'b0;
        tick();

        // ---- single triangle, halt=1 ----
        set_wr(0, 1'b1, 1'b0);
        tick();
        set_wr(0, 1'b0, 1'b0);
        $display("t1: wrote triangle 0");
        check("t1_valid_k", validTri_R10H, 1'b0);
        tick();
        check("t1_valid_k1", validTri_R10H, 1'b1);
        check_data("t1_data", 0);
        tick();
        check("t1_valid_drop", validTri_R10H, 1'b0);
        check("t1_sent", tri_sent_count, 32'd1);
        check("t1_stall", stall_count, 32'd0);

        // ---- 4 back-to-back, halt=1 ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_wr(i + 1, 1'b1, 1'b0);
            else       set_wr(0, 1'b0, 1'b0);
            tick();
            $display("t2: edge %0d valid=%0b", i, validTri_R10H);
            if (i >= 1 && i <= 4) begin
                check($sformatf("t2_valid%0d", i), validTri_R10H, 1'b1);
                check_data($sformatf("t2_data%0d", i), i);
            end else begin
                check($sformatf("t2_valid%0d", i), validTri_R10H, 1'b0);
            end
        end
        check("t2_sent", tri_sent_count, 32'd4);

        // ---- stall for 5 cycles ----
        do_reset();
        set_wr(10, 1'b1, 1'b0);
        tick();
        set_wr(0, 1'b0, 1'b0);
        halt_RnnnnL = 1'b0;
        tick();
        check("t3_valid0", validTri_R10H, 1'b1);
        check_data("t3_data0", 10);
        for (int i = 1; i <= 5; i++) begin
            tick();
            $display("t3: stall cycle %0d", i);
            check($sformatf("t3_valid%0d", i), validTri_R10H, 1'b1);
            check_data($sformatf("t3_data%0d", i), 10);
        end
        check("t3_stall", stall_count, 32'd5);
        check("t3_sent0", tri_sent_count, 32'd0);
        halt_RnnnnL = 1'b1;
        tick();
        check("t3_valid_drop", validTri_R10H, 1'b0);
        check("t3_sent", tri_sent_count, 32'd1);
        check("t3_stall_end", stall_count, 32'd5);

        // ---- fill to full under halt, overflow, then drain ----
        do_reset();
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_wr(20 + i, 1'b1, 1'b0);
            if (i == 8) check("t4_full_before9", wr_full, 1'b0);
            tick();
            $display("t4: wrote triangle %0d full=%0b", 20 + i, wr_full);
        end
        check("t4_full", wr_full, 1'b1);
        check("t4_ovf0", overflow, 1'b0);
        set_wr(29, 1'b1, 1'b0);
        tick();
        set_wr(0, 1'b0, 1'b0);
        check("t4_ovf", overflow, 1'b1);
        check("t4_full_held", wr_full, 1'b1);
        check("t4_stall", stall_count, 32'd8);
        halt_RnnnnL = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_valid%0d", i), validTri_R10H, 1'b1);
            check_data($sformatf("t4_data%0d", i), 20 + i);
            tick();
            $display("t4: drained triangle %0d", 20 + i);
        end
        check("t4_valid_end", validTri_R10H, 1'b0);
        check("t4_sent", tri_sent_count, 32'd9);
        check("t4_ovf_sticky", overflow, 1'b1);

        // ---- stream with last flag, halt toggling ----
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            halt_RnnnnL = (e % 2 == 1);
            if (e <= 3) set_wr(29 + e, 1'b1, (e == 3));
            else        set_wr(0, 1'b0, 1'b0);
            tick();
            $display("t5: edge %0d valid=%0b sent=%0d stall=%0d done=%0b",
                     e, validTri_R10H, tri_sent_count, stall_count, done);
            check($sformatf("t5_valid%0d", e), validTri_R10H, t5_valid[e-1]);
            check($sformatf("t5_sent%0d", e), tri_sent_count, 32'(t5_sent[e-1]));
            check($sformatf("t5_stall%0d", e), stall_count, 32'(t5_stall[e-1]));
            check($sformatf("t5_done%0d", e), done, t5_done[e-1]);
            if (t5_valid[e-1]) check_data($sformatf("t5_data%0d", e), t5_tri[e-1]);
        end

        // ---- reset mid-stream ----
        do_reset();
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(40 + i, 1'b1, 1'b1);
            tick();
        end
        set_wr(0, 1'b0, 1'b0);
        check("t6_pre_valid", validTri_R10H, 1'b1);
        check("t6_pre_stall", stall_count, 32'd2);
        rst = 1'b1;
        #1;
        $display("t6: reset asserted mid-stream");
        check("t6_valid", validTri_R10H, 1'b0);
        check("t6_sent", tri_sent_count, 32'd0);
        check("t6_stall", stall_count, 32'd0);
        check("t6_full", wr_full, 1'b0);
        tick();
        rst = 1'b0;
        halt_RnnnnL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_no_stale%0d", i), validTri_R10H, 1'b0);
        end
        check("t6_sent_end", tri_sent_count, 32'd0);
        check("t6_done", done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
